// File: rtl/ibram_rd_controller.sv
// rtl/ibram_rd_controller.sv - banked IBRAM read sweeper with credit-controlled output FIFO
module ibram_rd_controller #(
   parameter int STREAM_WIDTH = 128,
   parameter int IBRAM_WIDTH  = STREAM_WIDTH,
   parameter int NUM_BANKS    = 16,
   parameter int IBRAM_DEPTH  = 128,
   parameter int ADDR_W       = $clog2(IBRAM_DEPTH),
   parameter int BANK_W       = $clog2(NUM_BANKS),
   parameter int PARAM_WIDTH  = BANK_W + ADDR_W,
   parameter int RD_LAT       = 2,
   parameter int FIFO_DEPTH   = RD_LAT + 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PARAM_WIDTH-1:0]           param_data_rd,
   input  logic                             param_data_valid_rd,
   output logic                             param_data_ready_rd,
   output logic [ADDR_W-1:0]                addrB,
   output logic [NUM_BANKS-1:0]             enB,
   input  logic [NUM_BANKS*IBRAM_WIDTH-1:0] doB,
   output logic [STREAM_WIDTH-1:0]          odata,
   output logic                             odata_valid,
   input  logic                             odata_ready,
   output logic                             odata_last,
   output logic                             rd_done,
   output logic                             busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [BANK_W-1:0]      nbank_q, nbank_d;
   logic [ADDR_W-1:0]      len_q, len_d;
   logic [ADDR_W-1:0]      addr_cnt_q, addr_cnt_d;
   logic [BANK_W-1:0]      bank_cnt_q, bank_cnt_d;
   logic [ADDR_W-1:0]      addrB_q, addrB_d;
   logic [NUM_BANKS-1:0]   enB_q, enB_d;
   logic                   iss_vld_q, iss_vld_d;
   logic [BANK_W-1:0]      iss_bank_q, iss_bank_d;
   logic                   iss_last_q, iss_last_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   rd_done_q, rd_done_d;

   logic                   vld_pipe_q  [RD_LAT];
   logic [BANK_W-1:0]      bank_pipe_q [RD_LAT];
   logic                   last_pipe_q [RD_LAT];

   logic [CNT_W-1:0]       inflight_q, inflight_d;
   logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [STREAM_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                   last_mem_q [FIFO_DEPTH];

   logic                   issue;
   logic                   last_issue;
   logic                   push;
   logic                   pop;
   logic [OCC_W-1:0]       occ;
   logic                   credit_ok;
   logic [STREAM_WIDTH-1:0] ret_data;
   logic                   ret_last;

   assign push     = vld_pipe_q[RD_LAT-1];
   assign ret_last = last_pipe_q[RD_LAT-1];
   assign pop      = (fifo_cnt_q != '0) && odata_ready;
   assign occ      = OCC_W'(inflight_q) + OCC_W'(fifo_cnt_q);
   // A slot being popped this cycle is already free for the read issued now,
   // which keeps one word per cycle flowing with a full pipe.
   assign credit_ok = (occ < OCC_W'(FIFO_DEPTH)) || pop;

   // Next-state logic: descriptor capture, read issue and sweep counters
   always_comb begin
      state_d    = state_q;
      nbank_d    = nbank_q;
      len_d      = len_q;
      addr_cnt_d = addr_cnt_q;
      bank_cnt_d = bank_cnt_q;
      addrB_d    = addrB_q;
      enB_d      = '0;
      iss_vld_d  = 1'b0;
      iss_bank_d = iss_bank_q;
      iss_last_d = 1'b0;
      issue      = 1'b0;
      last_issue = (addr_cnt_q == len_q) && (bank_cnt_q == nbank_q);
      case (state_q)
         S_IDLE: begin
            if (param_data_valid_rd && ready_q) begin
               nbank_d    = param_data_rd[PARAM_WIDTH-1:ADDR_W];
               len_d      = param_data_rd[ADDR_W-1:0];
               addr_cnt_d = '0;
               bank_cnt_d = '0;
               state_d    = S_READ;
            end
         end
         S_READ: begin
            if (credit_ok) begin
               issue      = 1'b1;
               enB_d      = NUM_BANKS'(1) << bank_cnt_q;
               addrB_d    = addr_cnt_q;
               iss_vld_d  = 1'b1;
               iss_bank_d = bank_cnt_q;
               iss_last_d = last_issue;
               if (bank_cnt_q == nbank_q) begin
                  bank_cnt_d = '0;
                  addr_cnt_d = addr_cnt_q + 1'b1;
               end else begin
                  bank_cnt_d = bank_cnt_q + 1'b1;
               end
               if (last_issue) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready_d   = (state_d == S_IDLE);
   assign busy_d    = (state_d == S_READ) || (state_d == S_DRAIN);
   assign rd_done_d = (state_d == S_DONE);

   assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
   assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

   // Control state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         nbank_q    <= '0;
         len_q      <= '0;
         addr_cnt_q <= '0;
         bank_cnt_q <= '0;
         addrB_q    <= '0;
         enB_q      <= '0;
         iss_vld_q  <= 1'b0;
         iss_bank_q <= '0;
         iss_last_q <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         rd_done_q  <= 1'b0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         nbank_q    <= nbank_d;
         len_q      <= len_d;
         addr_cnt_q <= addr_cnt_d;
         bank_cnt_q <= bank_cnt_d;
         addrB_q    <= addrB_d;
         enB_q      <= enB_d;
         iss_vld_q  <= iss_vld_d;
         iss_bank_q <= iss_bank_d;
         iss_last_q <= iss_last_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         rd_done_q  <= rd_done_d;
         inflight_q <= inflight_d;
      end
   end

   // Bank index and last flag travel alongside the BRAM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_pipe_q[i]  <= 1'b0;
            bank_pipe_q[i] <= '0;
            last_pipe_q[i] <= 1'b0;
         end
      end else begin
         vld_pipe_q[0]  <= iss_vld_q;
         bank_pipe_q[0] <= iss_bank_q;
         last_pipe_q[0] <= iss_vld_q && iss_last_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            bank_pipe_q[i] <= bank_pipe_q[i-1];
            last_pipe_q[i] <= last_pipe_q[i-1];
         end
      end
   end

   // Select the returning bank's word
   always_comb begin
      ret_data = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (bank_pipe_q[RD_LAT-1] == BANK_W'(i)) begin
            ret_data = doB[i*IBRAM_WIDTH +: IBRAM_WIDTH];
         end
      end
   end

   // Output FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i]      <= '0;
            last_mem_q[i] <= 1'b0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q]      <= ret_data;
            last_mem_q[wr_ptr_q] <= ret_last;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   assign param_data_ready_rd = ready_q;
   assign addrB               = addrB_q;
   assign enB                 = enB_q;
   assign odata               = mem_q[rd_ptr_q];
   assign odata_valid         = (fifo_cnt_q != '0);
   assign odata_last          = odata_valid && last_mem_q[rd_ptr_q];
   assign rd_done             = rd_done_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_ibram_rd_controller.sv
// tb/tb_ibram_rd_controller.sv - self-checking bench for ibram_rd_controller
module tb_ibram_rd_controller;

   localparam int W      = 128;
   localparam int NB     = 16;
   localparam int AW     = 7;
   localparam int BW     = 4;
   localparam int PW     = BW + AW;
   localparam int RD_LAT = 2;
   localparam int FD     = RD_LAT + 2;

   logic              clk;
   logic              rst_n;
   logic [PW-1:0]     param_data_rd;
   logic              param_data_valid_rd;
   logic              param_data_ready_rd;
   logic [AW-1:0]     addrB;
   logic [NB-1:0]     enB;
   logic [NB*W-1:0]   doB;
   logic [W-1:0]      odata;
   logic              odata_valid;
   logic              odata_ready;
   logic              odata_last;
   logic              rd_done;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ibram_rd_controller #(
      .STREAM_WIDTH(W), .IBRAM_WIDTH(W), .NUM_BANKS(NB), .IBRAM_DEPTH(128),
      .ADDR_W(AW), .BANK_W(BW), .PARAM_WIDTH(PW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .param_data_rd(param_data_rd), .param_data_valid_rd(param_data_valid_rd),
      .param_data_ready_rd(param_data_ready_rd),
      .addrB(addrB), .enB(enB), .doB(doB),
      .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready),
      .odata_last(odata_last), .rd_done(rd_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] word_of(input int b, input int a);
      logic [15:0] t;
      t = {b[7:0], a[7:0]};
      return {t, ~t, t + 16'h1111, t ^ 16'h5a5a, 64'(b * 1000 + a)};
   endfunction

   // Banked BRAM with two-cycle enable-to-data latency; each bank holds its last read
   logic [NB-1:0]   s0_en = '0;
   logic [AW-1:0]   s0_addr = '0;
   logic [NB*W-1:0] dob_q = '0;
   always @(posedge clk) begin
      s0_en   <= enB;
      s0_addr <= addrB;
      for (int i = 0; i < NB; i++) begin
         if (s0_en[i]) dob_q[i*W +: W] <= word_of(i, int'(s0_addr));
      end
   end
   assign doB = dob_q;

   task automatic chk_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic chk_true(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // One full sweep; caller is positioned at a negedge
   task automatic run_sweep(input int nb, input int len, input int mode, input int exp_words,
                            input bit hold_next, input int nb2, input int len2);
      logic [W-1:0] exp_q[$];
      bit           expl_q[$];
      logic [W-1:0] ew, prev_data;
      bit           el, accepted, dropped, done_seen, prev_stalled, r;
      int accept_cyc, first_cyc, last_pop_cyc, done_cyc;
      int pops, issued, max_out, ready_viol, last_cnt, stall, onehot_err, busy_err;
      for (int a = 0; a <= len; a++)
         for (int b = 0; b <= nb; b++) begin
            exp_q.push_back(word_of(b, a));
            expl_q.push_back(1'b0);
         end
      expl_q[expl_q.size()-1] = 1'b1;
      accepted = 0; dropped = 0; done_seen = 0; prev_stalled = 0; prev_data = '0;
      accept_cyc = 0; first_cyc = -1; last_pop_cyc = 0; done_cyc = 0;
      pops = 0; issued = 0; max_out = 0; ready_viol = 0; last_cnt = 0; stall = 0;
      onehot_err = 0; busy_err = 0;
      param_data_rd = {nb[BW-1:0], len[AW-1:0]};
      param_data_valid_rd = 1'b1;
      odata_ready = 1'b1;
      for (int c = 0; c < 30000 && !done_seen; c++) begin
         if (accepted && !dropped) begin
            dropped = 1;
            if (hold_next) param_data_rd = {nb2[BW-1:0], len2[AW-1:0]};
            else param_data_valid_rd = 1'b0;
         end
         if (!accepted) begin
            if (param_data_ready_rd && param_data_valid_rd) begin
               accepted = 1;
               accept_cyc = cyc + 1;
            end
         end else begin
            if (param_data_ready_rd) ready_viol++;
            if (!busy && !rd_done && dropped) busy_err++;
         end
         if (enB != '0) issued++;
         if ($countones(enB) > 1) onehot_err++;
         if (issued - pops > max_out) max_out = issued - pops;
         if (odata_valid && first_cyc < 0) begin
            first_cyc = cyc;
            if (mode == 1) stall = 10;
         end
         if (prev_stalled) chk_eq("stall_hold", odata, prev_data);
         case (mode)
            0: r = 1'b1;
            1: begin r = (stall == 0); if (stall > 0) stall--; end
            default: r = 1'($urandom_range(0, 1));
         endcase
         odata_ready = r;
         if (odata_valid && odata_ready) begin
            if (exp_q.size() == 0) begin
               chk_true(0, "extra_word", pops + 1, exp_words);
            end else begin
               ew = exp_q.pop_front();
               el = expl_q.pop_front();
               chk_eq("odata", odata, ew);
               chk_eq("odata_last", W'(odata_last), W'(el));
            end
            if (odata_last) last_cnt++;
            pops++;
            last_pop_cyc = cyc;
         end
         prev_stalled = odata_valid && !odata_ready;
         prev_data = odata;
         if (rd_done) begin
            done_seen = 1;
            done_cyc = cyc;
            chk_true(busy == 1'b0, "busy_at_done", int'(busy), 0);
         end else begin
            @(negedge clk);
         end
      end
      if (!hold_next) param_data_valid_rd = 1'b0;
      chk_true(done_seen, "rd_done_seen", int'(done_seen), 1);
      chk_true(pops == exp_words, "word_count", pops, exp_words);
      chk_true(last_cnt == 1, "last_count", last_cnt, 1);
      chk_true(first_cyc - accept_cyc == RD_LAT + 2, "first_latency", first_cyc - accept_cyc, RD_LAT + 2);
      chk_true(done_cyc - last_pop_cyc == 2, "done_after_pop", done_cyc - last_pop_cyc, 2);
      chk_true(ready_viol == 0, "ready_during_sweep", ready_viol, 0);
      chk_true(busy_err == 0, "busy_during_sweep", busy_err, 0);
      chk_true(onehot_err == 0, "enB_onehot", onehot_err, 0);
      chk_true(max_out <= FD, "outstanding_bound", max_out, FD);
      if (mode == 0) chk_true(last_pop_cyc - first_cyc == exp_words - 1, "back_to_back",
                              last_pop_cyc - first_cyc, exp_words - 1);
      if (mode == 1) chk_true(max_out == FD, "stall_fills_fifo", max_out, FD);
      @(negedge clk);
      chk_true(rd_done == 1'b0, "rd_done_one_cycle", int'(rd_done), 0);
      chk_true(param_data_ready_rd == 1'b1, "ready_after_done", int'(param_data_ready_rd), 1);
   endtask

   typedef struct {
      int nb; int len; int mode; int exp_words; bit hold; int nb2; int len2;
   } vec_t;

   vec_t vecs[7];
   bit   acc;
   int   bad;

   initial begin
      vecs[0] = '{3,   1, 0,    8, 1'b0, 0, 0};
      vecs[1] = '{3,   1, 1,    8, 1'b0, 0, 0};
      vecs[2] = '{0,   0, 0,    1, 1'b0, 0, 0};
      vecs[3] = '{15, 127, 2, 2048, 1'b0, 0, 0};
      vecs[4] = '{2,   4, 2,   15, 1'b1, 1, 3};
      vecs[5] = '{1,   3, 0,    8, 1'b0, 0, 0};
      vecs[6] = '{7,   9, 1,   80, 1'b0, 0, 0};

      rst_n = 1'b0;
      param_data_rd = '0;
      param_data_valid_rd = 1'b0;
      odata_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_true(param_data_ready_rd == 1'b0, "reset_ready", int'(param_data_ready_rd), 0);
      chk_true(enB == '0 && addrB == '0, "reset_bram_port", int'(enB), 0);
      chk_eq("reset_odata", odata, '0);
      chk_true(!odata_valid && !odata_last && !rd_done && !busy, "reset_flags",
               int'({odata_valid, odata_last, rd_done, busy}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_true(param_data_ready_rd == 1'b1, "idle_ready", int'(param_data_ready_rd), 1);

      for (int v = 0; v < 7; v++)
         run_sweep(vecs[v].nb, vecs[v].len, vecs[v].mode, vecs[v].exp_words,
                   vecs[v].hold, vecs[v].nb2, vecs[v].len2);

      // Reset in the middle of a read sweep
      param_data_rd = {4'd3, 7'd1};
      param_data_valid_rd = 1'b1;
      odata_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 20 && !acc; c++) begin
         if (param_data_ready_rd) acc = 1;
         @(negedge clk);
      end
      chk_true(acc, "reset_test_accept", int'(acc), 1);
      param_data_valid_rd = 1'b0;
      repeat (2) @(negedge clk);
      chk_true(busy == 1'b1, "busy_before_reset", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_true(enB == '0 && addrB == '0, "async_reset_bram_port", int'(enB), 0);
      chk_eq("async_reset_odata", odata, '0);
      chk_true(!odata_valid && !odata_last && !rd_done && !busy && !param_data_ready_rd,
               "async_reset_flags", int'({odata_valid, odata_last, rd_done, busy, param_data_ready_rd}), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (rd_done || odata_valid || busy || enB != '0) bad++;
         @(negedge clk);
      end
      chk_true(bad == 0, "quiet_after_reset", bad, 0);
      run_sweep(3, 1, 0, 8, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
